// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: DEPTH-stage elastic register chain with valid/ready on both
// sides. Empty stages fill immediately so a downstream stall lets upstream
// words pack forward. Includes a synchronous flush and a registered occupancy.
module pipe_reg_hs #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [3:0]       occupancy
);

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] dat_p [DEPTH];
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] vld_nxt;
  logic             out_of_reset;

  function automatic logic [3:0] popcount(input logic [DEPTH-1:0] bits);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + {3'b000, bits[i]};
    end
    return cnt;
  endfunction

  // Ready chain from the output side: a stage can load if it is empty or its word moves on.
  always_comb begin : ready_chain
    logic r;
    r = m_ready;
    rdy = '0;
    rdy[DEPTH] = m_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r = !vld_p[i] || r;
      rdy[i] = r;
    end
  end

  assign s_ready = rdy[0] && out_of_reset && !flush;
  assign m_valid = vld_p[DEPTH-1];
  assign m_data  = dat_p[DEPTH-1];

  // Next valid vector: flush clears everything, otherwise ready stages take the upstream valid.
  always_comb begin
    vld_nxt = vld_p;
    if (flush) begin
      vld_nxt = '0;
    end else begin
      if (rdy[0]) vld_nxt[0] = s_valid && s_ready;
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) vld_nxt[i] = vld_p[i-1];
      end
    end
  end

  // Control state: stage valids, occupancy and the one-cycle post-reset input block.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p        <= '0;
      occupancy    <= '0;
      out_of_reset <= 1'b0;
    end else begin
      vld_p        <= vld_nxt;
      occupancy    <= popcount(vld_nxt);
      out_of_reset <= 1'b1;
    end
  end

  // Stage data: loads only when a valid word arrives, so bubbles never overwrite held data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) dat_p[i] <= RESET_VAL;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) dat_p[i] <= RESET_VAL;
    end else begin
      if (rdy[0] && s_valid && s_ready) dat_p[0] <= s_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i] && vld_p[i-1]) dat_p[i] <= dat_p[i-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Testbench for pipe_reg_hs: directed scenarios plus random traffic against a
// position-based queue model (DEPTH=3), and a DEPTH=1 scoreboard check.
module tb_pipe_reg_hs;
  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, m_valid;
  logic [7:0] m_data;
  logic [3:0] occupancy;

  logic       flush1 = 1'b0, s1_valid = 1'b0, m1_ready = 1'b0;
  logic [7:0] s1_data = 8'h00;
  logic       s1_ready, m1_valid;
  logic [7:0] m1_data;
  logic [3:0] occ1;

  int checks = 0;
  int errors = 0;

  // Model: queue of words, each with its stage position (front = oldest = highest position).
  logic [7:0] mq[$];
  int         pq[$];
  int         pn[$];
  bit         oor_m, leave;
  bit         exp_sready, exp_mvalid;
  logic [7:0] exp_mdata;
  bit         got_sready, got_mvalid;
  logic [7:0] got_mdata;

  pipe_reg_hs #(.WIDTH(8), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .occupancy(occupancy)
  );

  pipe_reg_hs #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
    .clk(clk), .resetn(resetn), .flush(flush1),
    .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data),
    .m_valid(m1_valid), .m_ready(m1_ready), .m_data(m1_data),
    .occupancy(occ1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq.delete();
    pq.delete();
    oor_m = 1'b0;
  endtask

  task automatic model_predict(input bit mr, input bit fl);
    int lim;
    exp_mvalid = (pq.size() > 0) && (pq[0] == D - 1);
    exp_mdata  = exp_mvalid ? mq[0] : 8'h00;
    leave = exp_mvalid && mr;
    pn = pq;
    if (leave) void'(pn.pop_front());
    for (int k = 0; k < pn.size(); k++) begin
      lim = (k == 0) ? D : pn[k-1];
      if (pn[k] + 1 < lim) pn[k] = pn[k] + 1;
    end
    exp_sready = oor_m && !fl && ((pn.size() == 0) || (pn[pn.size()-1] != 0));
  endtask

  task automatic model_commit(input bit sv, input logic [7:0] sd, input bit fl);
    if (fl) begin
      mq.delete();
      pq.delete();
    end else begin
      if (leave) void'(mq.pop_front());
      pq = pn;
      if (sv && exp_sready) begin
        mq.push_back(sd);
        pq.push_back(0);
      end
    end
    oor_m = 1'b1;
  endtask

  // One clock: drive at negedge, sample pre-edge, update model at posedge, return at negedge.
  task automatic cycle(input bit sv, input logic [7:0] sd, input bit mr, input bit fl);
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
    #1;
    got_sready = s_ready; got_mvalid = m_valid; got_mdata = m_data;
    model_predict(mr, fl);
    @(posedge clk);
    model_commit(sv, sd, fl);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_mvalid got=%0b exp=0", m_valid); end
    checks++; if (m_data !== RV) begin errors++; $display("FAIL reset_mdata got=%h exp=%h", m_data, RV); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_sready got=%0b exp=0", s_ready); end
    model_reset();
    resetn = 1'b1;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (got_sready !== 1'b0) begin errors++; $display("FAIL release_sready_first got=%0b exp=0", got_sready); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (got_sready !== 1'b1) begin errors++; $display("FAIL release_sready_second got=%0b exp=1", got_sready); end
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL prefill_mvalid got=%0b exp=1", m_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midreset_mvalid got=%0b exp=0", m_valid); end
    checks++; if (m_data !== RV) begin errors++; $display("FAIL midreset_mdata got=%h exp=%h", m_data, RV); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL midreset_occ got=%0d exp=0", occupancy); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midreset_sready got=%0b exp=0", s_ready); end
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (got_sready !== 1'b0) begin errors++; $display("FAIL rerelease_sready_first got=%0b exp=0", got_sready); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (got_sready !== 1'b1) begin errors++; $display("FAIL rerelease_sready_second got=%0b exp=1", got_sready); end
  endtask

  task automatic test_streaming();
    int first_acc, first_mv, last_mv, nxt_in, nxt_out;
    bit sv;
    first_acc = -1; first_mv = -1; last_mv = -1; nxt_in = 1; nxt_out = 1;
    for (int c = 0; c < 60 && nxt_out <= 16; c++) begin
      sv = (nxt_in <= 16);
      cycle(sv, 8'(nxt_in), 1'b1, 1'b0);
      if (sv) begin
        checks++; if (got_sready !== 1'b1) begin errors++; $display("FAIL stream_sready cyc=%0d got=%0b exp=1", c, got_sready); end
        if (got_sready) begin
          if (first_acc < 0) first_acc = c;
          nxt_in++;
        end
      end
      checks++; if (got_mvalid !== exp_mvalid) begin errors++; $display("FAIL stream_mvalid cyc=%0d got=%0b exp=%0b", c, got_mvalid, exp_mvalid); end
      if (got_mvalid) begin
        if (first_mv < 0) first_mv = c;
        last_mv = c;
        checks++; if (got_mdata !== 8'(nxt_out)) begin errors++; $display("FAIL stream_data got=%h exp=%h", got_mdata, 8'(nxt_out)); end
        nxt_out++;
      end
    end
    checks++; if (nxt_out != 17) begin errors++; $display("FAIL stream_count got=%0d exp=16", nxt_out - 1); end
    checks++; if (first_mv - first_acc != 3) begin errors++; $display("FAIL stream_latency got=%0d exp=3", first_mv - first_acc); end
    checks++; if (last_mv - first_mv != 15) begin errors++; $display("FAIL stream_throughput got=%0d exp=15", last_mv - first_mv); end
  endtask

  task automatic test_backpressure();
    logic [7:0] words[4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, words[k], 1'b0, 1'b0);
      checks++; if (got_sready !== (k < 3)) begin errors++; $display("FAIL fill_sready k=%0d got=%0b exp=%0b", k, got_sready, (k < 3)); end
      if (k < 3) begin
        checks++; if (occupancy !== 4'(k + 1)) begin errors++; $display("FAIL fill_occ k=%0d got=%0d exp=%0d", k, occupancy, k + 1); end
      end else begin
        checks++; if (got_mvalid !== 1'b1 || got_mdata !== 8'h11) begin errors++; $display("FAIL fill_hold got=%0b/%h exp=1/11", got_mvalid, got_mdata); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      cycle(k == 0, 8'h44, 1'b1, 1'b0);
      if (k == 0) begin
        checks++; if (got_sready !== 1'b1) begin errors++; $display("FAIL full_swap_sready got=%0b exp=1", got_sready); end
        checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL full_swap_occ got=%0d exp=3", occupancy); end
      end
      checks++; if (got_mvalid !== 1'b1 || got_mdata !== words[k]) begin errors++; $display("FAIL drain_data k=%0d got=%0b/%h exp=1/%h", k, got_mvalid, got_mdata, words[k]); end
    end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL drain_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_bubble();
    logic [7:0] words[3];
    words[0] = 8'h5A; words[1] = 8'h6B; words[2] = 8'h7C;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (m_valid !== 1'b0 || occupancy !== 4'd1) begin errors++; $display("FAIL bubble_mid got=%0b/%0d exp=0/1", m_valid, occupancy); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A || occupancy !== 4'd1) begin errors++; $display("FAIL bubble_arrive got=%0b/%h/%0d exp=1/5a/1", m_valid, m_data, occupancy); end
    cycle(1'b1, 8'h6B, 1'b0, 1'b0);
    checks++; if (got_sready !== 1'b1 || occupancy !== 4'd2) begin errors++; $display("FAIL bubble_pack got=%0b/%0d exp=1/2", got_sready, occupancy); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h7C, 1'b0, 1'b0);
    checks++; if (got_sready !== 1'b1 || occupancy !== 4'd3) begin errors++; $display("FAIL bubble_third got=%0b/%0d exp=1/3", got_sready, occupancy); end
    cycle(1'b1, 8'h8D, 1'b0, 1'b0);
    checks++; if (got_sready !== 1'b0) begin errors++; $display("FAIL bubble_full_sready got=%0b exp=0", got_sready); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (got_mvalid !== 1'b1 || got_mdata !== words[k]) begin errors++; $display("FAIL bubble_drain k=%0d got=%0b/%h exp=1/%h", k, got_mvalid, got_mdata, words[k]); end
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL flush_prefill_occ got=%0d exp=3", occupancy); end
    cycle(1'b1, 8'hFF, 1'b0, 1'b1);
    checks++; if (got_sready !== 1'b0) begin errors++; $display("FAIL flush_sready got=%0b exp=0", got_sready); end
    checks++; if (occupancy !== 4'd0 || m_valid !== 1'b0 || m_data !== RV) begin errors++; $display("FAIL flush_state got=%0d/%0b/%h exp=0/0/%h", occupancy, m_valid, m_data, RV); end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (got_mvalid !== 1'b0) begin errors++; $display("FAIL flush_leak k=%0d got=%0b/%h exp=0", k, got_mvalid, got_mdata); end
    end
  endtask

  task automatic test_random();
    bit sv, mr, fl;
    logic [7:0] sd;
    for (int c = 0; c < 400; c++) begin
      sv = ($urandom % 3) != 0;
      mr = ($urandom % 4) != 0;
      fl = ($urandom % 25) == 0;
      sd = 8'($urandom);
      cycle(sv, sd, mr, fl);
      checks++; if (got_sready !== exp_sready) begin errors++; $display("FAIL rand_sready cyc=%0d got=%0b exp=%0b", c, got_sready, exp_sready); end
      checks++; if (got_mvalid !== exp_mvalid) begin errors++; $display("FAIL rand_mvalid cyc=%0d got=%0b exp=%0b", c, got_mvalid, exp_mvalid); end
      if (exp_mvalid) begin
        checks++; if (got_mdata !== exp_mdata) begin errors++; $display("FAIL rand_mdata cyc=%0d got=%h exp=%h", c, got_mdata, exp_mdata); end
      end
      checks++; if (occupancy !== 4'(mq.size())) begin errors++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", c, occupancy, mq.size()); end
    end
    s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_depth1();
    logic [7:0] sent[$];
    int nd, rcv;
    nd = 1; rcv = 0;
    for (int c = 0; c < 64; c++) begin
      s1_valid = 1'b1; s1_data = 8'(nd); m1_ready = c[0];
      #1;
      checks++; if (s1_ready !== (!m1_valid || m1_ready)) begin errors++; $display("FAIL d1_sready cyc=%0d got=%0b exp=%0b", c, s1_ready, (!m1_valid || m1_ready)); end
      if (m1_valid && m1_ready) begin
        checks++;
        if (sent.size() == 0) begin errors++; $display("FAIL d1_dup got=%h exp=none", m1_data); end
        else begin
          if (m1_data !== sent[0]) begin errors++; $display("FAIL d1_order got=%h exp=%h", m1_data, sent[0]); end
          void'(sent.pop_front());
        end
        rcv++;
      end
      if (s1_ready) begin
        sent.push_back(8'(nd));
        nd++;
      end
      @(negedge clk);
    end
    s1_valid = 1'b0; m1_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (m1_valid) begin
        checks++;
        if (sent.size() == 0 || m1_data !== sent[0]) begin errors++; $display("FAIL d1_drain got=%h", m1_data); end
        if (sent.size() > 0) void'(sent.pop_front());
        rcv++;
      end
      @(negedge clk);
    end
    checks++; if (sent.size() != 0) begin errors++; $display("FAIL d1_lost got=%0d exp=0", sent.size()); end
    checks++; if (rcv < 20) begin errors++; $display("FAIL d1_count got=%0d exp>=20", rcv); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();
    test_depth1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
